// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-requester ALU arbiter.
package alu_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   localparam int NUM_ARB_REQ = 2;

endpackage

// File: rtl/alu_arbiter_rr_grant2.sv
// Combinational two-way grant. With ALU_ARB_FIXED_PRIO_EN defined port 0 always
// wins contention; otherwise the port not granted last wins.
module rr_grant2 (
`ifndef ALU_ARB_FIXED_PRIO_EN
   input  logic last,
`endif
   input  logic valid0,
   input  logic valid1,
   output logic any_valid,
   output logic gnt
);

   assign any_valid = valid0 | valid1;

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign gnt = ~valid0;
`else
   // A lone requester always wins; under contention alternate away from last.
   assign gnt = (valid0 & valid1) ? ~last : valid1;
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared combinational ALU, one transaction
// in flight (IDLE -> EXEC -> RESP). Optional build macro: ALU_ARB_FIXED_PRIO_EN.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int W   = 8,
   parameter int Ops = 3
) (
   input  logic           Clk,
   input  logic           Reset_n,
   input  logic           Req0Valid,
   input  logic           Req1Valid,
   output logic           Req0Ready,
   output logic           Req1Ready,
   input  logic [W-1:0]   Req0A,
   input  logic [W-1:0]   Req0B,
   input  logic [W-1:0]   Req1A,
   input  logic [W-1:0]   Req1B,
   input  logic [Ops-1:0] Req0Op,
   input  logic [Ops-1:0] Req1Op,
   input  logic           Req0SC,
   input  logic           Req1SC,
   output logic [W-1:0]   AluA,
   output logic [W-1:0]   AluB,
   output logic [Ops-1:0] AluOp,
   output logic           AluSC,
   input  logic [W-1:0]   AluOut,
   input  logic           AluZero,
   input  logic           AluParity,
   input  logic           AluOdd,
   output logic           RspValid,
   input  logic           RspReady,
   output logic           RspId,
   output logic [W-1:0]   RspOut,
   output logic           RspZero,
   output logic           RspParity,
   output logic           RspOdd,
   output logic           Busy
);

   arb_state_e     state_q, state_d;
   logic           any_valid, grant, accept;

   logic [W-1:0]   opnd_a_p0, opnd_b_p0;
   logic [Ops-1:0] opnd_op_p0;
   logic           opnd_sc_p0, opnd_id_p0;

   logic [W-1:0]   rsp_out_p1;
   logic           rsp_zero_p1, rsp_parity_p1, rsp_odd_p1, rsp_id_p1;

`ifndef ALU_ARB_FIXED_PRIO_EN
   logic           last_q;
`endif

   rr_grant2 u_grant (
`ifndef ALU_ARB_FIXED_PRIO_EN
      .last      (last_q),
`endif
      .valid0    (Req0Valid),
      .valid1    (Req1Valid),
      .any_valid (any_valid),
      .gnt       (grant)
   );

   assign accept = (state_q == IDLE) && any_valid;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_valid) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (RspReady) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      Req0Ready = accept && !grant;
      Req1Ready = accept && grant;
      Busy      = (state_q != IDLE);
      RspValid  = (state_q == RESP);
      AluA      = '0;
      AluB      = '0;
      AluOp     = '0;
      AluSC     = 1'b0;
      if (state_q == EXEC) begin
         AluA  = opnd_a_p0;
         AluB  = opnd_b_p0;
         AluOp = opnd_op_p0;
         AluSC = opnd_sc_p0;
      end
   end

`ifndef ALU_ARB_FIXED_PRIO_EN
   // Reset value 1 lets port 0 win the first contention.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)    last_q <= 1'b1;
      else if (accept) last_q <= grant;
   end
`endif

   // Stage p0: operand capture at acceptance
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         opnd_a_p0  <= '0;
         opnd_b_p0  <= '0;
         opnd_op_p0 <= '0;
         opnd_sc_p0 <= 1'b0;
         opnd_id_p0 <= 1'b0;
      end else if (accept) begin
         opnd_a_p0  <= grant ? Req1A  : Req0A;
         opnd_b_p0  <= grant ? Req1B  : Req0B;
         opnd_op_p0 <= grant ? Req1Op : Req0Op;
         opnd_sc_p0 <= grant ? Req1SC : Req0SC;
         opnd_id_p0 <= grant;
      end
   end

   // Stage p1: ALU result capture at the end of EXEC
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rsp_out_p1    <= '0;
         rsp_zero_p1   <= 1'b0;
         rsp_parity_p1 <= 1'b0;
         rsp_odd_p1    <= 1'b0;
         rsp_id_p1     <= 1'b0;
      end else if (state_q == EXEC) begin
         rsp_out_p1    <= AluOut;
         rsp_zero_p1   <= AluZero;
         rsp_parity_p1 <= AluParity;
         rsp_odd_p1    <= AluOdd;
         rsp_id_p1     <= opnd_id_p0;
      end
   end

   assign RspOut    = rsp_out_p1;
   assign RspZero   = rsp_zero_p1;
   assign RspParity = rsp_parity_p1;
   assign RspOdd    = rsp_odd_p1;
   assign RspId     = rsp_id_p1;

endmodule
